skolem_sweep_checker: RTL and testbench

//  Exhaustive verifier for a Skolem-function candidate. Drives every x-assignment
//  (0 .. 2^NX-1) onto x_vec. The external candidate maps x_vec to the i-variables,
//  and the combinational formula block returns formula_out. Counts failures,

---
 rtl/skolem_sweep_checker_pkg.sv | 12 +
 rtl/skolem_sweep_checker_if.sv | 12 +
 rtl/skolem_sweep_checker_accum.sv | 65 ++++++
 rtl/skolem_sweep_checker.sv | 108 ++++++++++
 tb/tb_skolem_sweep_checker.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/skolem_sweep_checker_pkg.sv
// rtl/skolem_sweep_checker_pkg.sv - shared types and sizing helpers for the Skolem sweep checker
package skolem_sweep_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int DEF_NX = 4;

  function automatic int cnt_w(input int nx);
    return nx + 1;
  endfunction

endpackage

// File: rtl/skolem_sweep_checker_if.sv
// rtl/skolem_sweep_checker_if.sv - checker-to-formula bus: x-assignment out, formula result back
interface skolem_sweep_checker_if #(
  parameter int NX = 4
) ();

  logic [NX-1:0] x_vec;
  logic          formula_out;

  modport master (output x_vec, input formula_out);
  modport slave  (input x_vec, output formula_out);

endinterface

// File: rtl/skolem_sweep_checker_accum.sv
// rtl/skolem_sweep_checker_accum.sv - stage-1 sample register, saturating counters, first-cex capture
module sweep_accum #(
  parameter int NX = 4,
  parameter int CW = NX + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          sample_en,
  input  logic          x_fresh,
  input  logic [NX-1:0] x_vec,
  input  logic          formula_out,
  output logic          fail_seen,
  output logic          last_counted,
  output logic          cex_valid,
  output logic [NX-1:0] cex_x,
  output logic [CW-1:0] fail_count,
  output logic [CW-1:0] tested_count
);

  localparam logic [CW-1:0] CNT_MAX = CW'(1) << NX;

  logic          s1_vld;
  logic [NX-1:0] s1_x;
  logic          s1_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld       <= 1'b0;
      s1_x         <= '0;
      s1_out       <= 1'b0;
      cex_valid    <= 1'b0;
      cex_x        <= '0;
      fail_count   <= '0;
      tested_count <= '0;
    end else if (clear) begin
      s1_vld       <= 1'b0;
      cex_valid    <= 1'b0;
      cex_x        <= '0;
      fail_count   <= '0;
      tested_count <= '0;
    end else begin
      // a held x_vec is re-sampled but never counted twice
      s1_vld <= sample_en && x_fresh;
      if (sample_en) begin
        s1_x   <= x_vec;
        s1_out <= formula_out;
      end
      if (s1_vld) begin
        if (tested_count != CNT_MAX) tested_count <= tested_count + CW'(1);
        if (!s1_out) begin
          if (fail_count != CNT_MAX) fail_count <= fail_count + CW'(1);
          if (!cex_valid) begin
            cex_valid <= 1'b1;
            cex_x     <= s1_x;
          end
        end
      end
    end
  end

  assign fail_seen    = s1_vld && !s1_out;
  assign last_counted = s1_vld && (s1_x == '1);

endmodule

// File: rtl/skolem_sweep_checker.sv
// rtl/skolem_sweep_checker.sv - exhaustive x-sweep driver and pass/fail reporter for a Skolem candidate
module skolem_sweep_checker
  import skolem_sweep_pkg::*;
#(
  parameter int  NX = DEF_NX,
  localparam int CW = cnt_w(NX)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   stop_on_fail,
  skolem_sweep_checker_if.master fml,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   cex_valid,
  output logic [NX-1:0]          cex_x,
  output logic [CW-1:0]          fail_count,
  output logic [CW-1:0]          tested_count
);

  localparam logic [NX-1:0] X_MAX = '1;

  state_t        state, state_n;
  logic [NX-1:0] x_cur, x_n;
  logic          fresh, fresh_n;
  logic          stop_lat, stop_n;
  logic          clear;
  logic          sample_en;
  logic          fail_seen;
  logic          last_counted;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      x_cur    <= '0;
      fresh    <= 1'b0;
      stop_lat <= 1'b0;
    end else begin
      state    <= state_n;
      x_cur    <= x_n;
      fresh    <= fresh_n;
      stop_lat <= stop_n;
    end
  end

  // RUN ends when the last vector reaches stage 2, so the single DRAIN cycle
  // only has to absorb the one vector still sitting in stage 1.
  always_comb begin
    state_n = state;
    x_n     = x_cur;
    fresh_n = 1'b0;
    stop_n  = stop_lat;
    clear   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          state_n = S_RUN;
          x_n     = '0;
          fresh_n = 1'b1;
          stop_n  = stop_on_fail;
          clear   = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (last_counted || (stop_lat && fail_seen)) begin
          state_n = S_DRAIN;
        end else if (x_cur != X_MAX) begin
          x_n     = x_cur + NX'(1);
          fresh_n = 1'b1;
        end
      end
      S_DRAIN: begin
        state_n = abort ? S_IDLE : S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign pass      = done && (fail_count == '0);
  assign sample_en = busy && !abort;
  assign fml.x_vec = x_cur;

  sweep_accum #(
    .NX(NX),
    .CW(CW)
  ) u_accum (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .sample_en   (sample_en),
    .x_fresh     (fresh),
    .x_vec       (x_cur),
    .formula_out (fml.formula_out),
    .fail_seen   (fail_seen),
    .last_counted(last_counted),
    .cex_valid   (cex_valid),
    .cex_x       (cex_x),
    .fail_count  (fail_count),
    .tested_count(tested_count)
  );

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// tb/tb_skolem_sweep_checker.sv - directed self-checking bench for skolem_sweep_checker
module tb_skolem_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       stop_on_fail = 1'b0;
  logic       mode = 1'b0;
  logic       busy, done, pass, cex_valid;
  logic [3:0] cex_x;
  logic [4:0] fail_count, tested_count;
  int         total = 0;
  int         bad = 0;
  int         n;
  int         rises;
  logic       done_prev;

  skolem_sweep_checker_if #(.NX(4)) fml ();

  // mode 0: tautology; mode 1: fails only at x=5 and x=12
  assign fml.formula_out = mode ? ((fml.x_vec != 4'h5) && (fml.x_vec != 4'hC)) : 1'b1;

  skolem_sweep_checker #(.NX(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .stop_on_fail(stop_on_fail),
    .fml         (fml.master),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .cex_valid   (cex_valid),
    .cex_x       (cex_x),
    .fail_count  (fail_count),
    .tested_count(tested_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 60) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_cexv", cex_valid, 0);
    chk("rst_fail", fail_count, 0);
    chk("rst_tested", tested_count, 0);
    chk("rst_x", fml.x_vec, 0);
    rst_n = 1'b1;
    tick();

    // T1: all-pass sweep
    mode = 1'b0;
    pulse_start();
    chk("t1_busy", busy, 1);
    wait_done(n);
    chk("t1_latency", n, 18);
    chk("t1_tested", tested_count, 16);
    chk("t1_fail", fail_count, 0);
    chk("t1_pass", pass, 1);
    chk("t1_cexv", cex_valid, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_x_hold", fml.x_vec, 15);

    // T2: two failures, no stop
    mode = 1'b1;
    stop_on_fail = 1'b0;
    pulse_start();
    wait_done(n);
    chk("t2_latency", n, 18);
    chk("t2_fail", fail_count, 2);
    chk("t2_cexv", cex_valid, 1);
    chk("t2_cex", cex_x, 5);
    chk("t2_pass", pass, 0);
    chk("t2_tested", tested_count, 16);

    // T6: restart from DONE clears results and re-sweeps cleanly
    mode = 1'b0;
    pulse_start();
    chk("t6_clr_tested", tested_count, 0);
    chk("t6_clr_fail", fail_count, 0);
    chk("t6_clr_cexv", cex_valid, 0);
    chk("t6_clr_done", done, 0);
    wait_done(n);
    chk("t6_latency", n, 18);
    chk("t6_tested", tested_count, 16);
    chk("t6_pass", pass, 1);

    // T3: stop at first failure; x=6 is in flight and still counted
    mode = 1'b1;
    stop_on_fail = 1'b1;
    pulse_start();
    stop_on_fail = 1'b0;
    wait_done(n);
    chk("t3_latency", n, 8);
    chk("t3_done", done, 1);
    chk("t3_cex", cex_x, 5);
    chk("t3_fail", fail_count, 1);
    chk("t3_tested", tested_count, 7);
    chk("t3_pass", pass, 0);

    // T4: abort 5 cycles after start, then a clean sweep
    mode = 1'b0;
    pulse_start();
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    tick();
    chk("t4_idle_busy", busy, 0);
    pulse_start();
    wait_done(n);
    chk("t4_latency", n, 18);
    chk("t4_tested", tested_count, 16);
    chk("t4_fail", fail_count, 0);
    chk("t4_pass", pass, 1);

    // T5: start pulses while busy are ignored, then reset mid-run
    pulse_start();
    rises = 0;
    done_prev = done;
    for (int i = 0; i < 40; i++) begin
      start = (i == 3) || (i == 7) || (i == 17);
      tick();
      if (done && !done_prev) rises++;
      done_prev = done;
    end
    start = 1'b0;
    chk("t5_rises", rises, 1);
    chk("t5_tested", tested_count, 16);
    chk("t5_pass", pass, 1);
    mode = 1'b1;
    pulse_start();
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_cexv", cex_valid, 0);
    chk("t5_rst_fail", fail_count, 0);
    chk("t5_rst_tested", tested_count, 0);
    chk("t5_rst_x", fml.x_vec, 0);
    tick();
    chk("t5_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
